// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit between the core and a req/gnt/rvalid data bus
// Optional size-alignment fault enabled by defining LSU_ALIGN_CHECK_EN.
module dmem_lsu #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    funct3,
  input  logic [63:0]   ALURes,
  input  logic [63:0]   readDataB,
  output logic [63:0]   readData,
  output logic          stall,
  output logic          fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic [7:0]    mem_wstrb,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [63:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] TLAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [1:0]  state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  off_q;
  logic [31:0] tcnt;

  logic        access;
  logic [2:0]  off;
  logic [2:0]  lowmask;
  logic [2:0]  off_eff;
  logic [7:0]  sizemask;
  logic [7:0]  strb;
  logic [63:0] wshift;
  logic        bad;
  logic [63:0] rsh;
  logic [63:0] ext;
  logic        timeout_hit;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^ALURes[63:AW];

  always_comb begin
    access   = MemRead | MemWrite;
    off      = ALURes[2:0];
    lowmask  = 3'b000;
    sizemask = 8'h01;
    case (funct3[1:0])
      2'b00:   begin lowmask = 3'b000; sizemask = 8'h01; end
      2'b01:   begin lowmask = 3'b001; sizemask = 8'h03; end
      2'b10:   begin lowmask = 3'b011; sizemask = 8'h0F; end
      default: begin lowmask = 3'b111; sizemask = 8'hFF; end
    endcase
    // Sub-size address bits are dropped so a lane never straddles the doubleword.
    off_eff = off & ~lowmask;
    strb    = sizemask << off_eff;
    wshift  = readDataB << {off_eff, 3'b000};
`ifdef LSU_ALIGN_CHECK_EN
    bad = (funct3 == 3'b111) | (MemWrite & funct3[2]) | (|(off & lowmask));
`else
    bad = (funct3 == 3'b111) | (MemWrite & funct3[2]);
`endif
  end

  always_comb begin
    rsh = mem_rdata >> {off_q, 3'b000};
    ext = rsh;
    case (size_q)
      2'b00:   ext = uns_q ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
      2'b01:   ext = uns_q ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      2'b10:   ext = uns_q ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: ext = rsh;
    endcase
    timeout_hit = (TIMEOUT > 0) && (tcnt == TLAST);
  end

  assign stall   = access & (state != S_DONE);
  assign mem_req = (state == S_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= 3'd0;
      tcnt      <= 32'd0;
      readData  <= 64'd0;
      fault     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 64'd0;
      mem_wstrb <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            size_q    <= funct3[1:0];
            uns_q     <= funct3[2];
            off_q     <= off_eff;
            tcnt      <= 32'd0;
            readData  <= 64'd0;
            fault     <= bad;
            mem_we    <= MemWrite;
            mem_addr  <= {ALURes[AW-1:3], 3'b000};
            mem_wdata <= MemWrite ? wshift : 64'd0;
            mem_wstrb <= MemWrite ? strb : 8'd0;
            state     <= bad ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) state <= mem_we ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            readData <= ext;
            state    <= S_DONE;
          end else if (timeout_hit) begin
            readData <= 64'd0;
            fault    <= 1'b1;
            state    <= S_DONE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu (TIMEOUT=8)
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] ALURes = 64'd0;
  logic [63:0] readDataB = 64'd0;
  logic [63:0] readData;
  logic        stall;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  int n_cmp = 0;
  int n_fail = 0;

  int          ns, nr, nu;
  logic [63:0] rr, aa, awd;
  logic [7:0]  aws;
  logic        fr, awe, done;

  always #5 clk = ~clk;

  dmem_lsu #(.AW(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALURes(ALURes), .readDataB(readDataB),
    .readData(readData), .stall(stall), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one core access; gnt after gdly REQ cycles, rvalid rdly cycles after gnt.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input int gdly, input int rdly, input logic [63:0] rdat);
    int gc;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALURes = addr; readDataB = wd;
    ns = 0; nr = 0; nu = 0; gc = -1; done = 1'b0;
    rr = '0; fr = 1'b0; aa = '0; awd = '0; aws = '0; awe = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!stall) begin
        rr = readData; fr = fault; done = 1'b1;
        break;
      end
      ns++;
      if (mem_req) begin
        if (nr == 0) begin
          aa = 64'(mem_addr); awd = mem_wdata; aws = mem_wstrb; awe = mem_we;
        end else if (64'(mem_addr) !== aa || mem_wdata !== awd || mem_wstrb !== aws || mem_we !== awe) begin
          nu++;
        end
        if (nr == gdly) begin
          mem_gnt = 1'b1;
          gc = c;
        end
        nr++;
      end
      if (gc >= 0 && c == gc + rdly) begin
        mem_rvalid = 1'b1;
        mem_rdata = rdat;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
    chk("access_bound", 64'(done), 64'd1);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #12;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_readData", readData, 64'd0);
    chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    access(1, 0, 3'b011, 64'h10, 64'd0, 0, 2, 64'h1122334455667788);
    chk("ld_stall_cycles", 64'(ns), 64'd4);
    chk("ld_data", rr, 64'h1122334455667788);
    chk("ld_fault", 64'(fr), 64'd0);
    chk("ld_addr", aa, 64'h10);
    chk("ld_we", 64'(awe), 64'd0);
    chk("ld_wstrb", 64'(aws), 64'd0);

    access(1, 0, 3'b000, 64'h13, 64'd0, 0, 1, 64'h0000000080000000);
    chk("lb_stall_cycles", 64'(ns), 64'd3);
    chk("lb_data", rr, 64'hFFFFFFFFFFFFFF80);
    access(1, 0, 3'b100, 64'h13, 64'd0, 0, 1, 64'h0000000080000000);
    chk("lbu_data", rr, 64'h0000000000000080);

    access(0, 1, 3'b001, 64'h6, 64'hABCD, 0, 99, 64'd0);
    chk("sh_stall_cycles", 64'(ns), 64'd2);
    chk("sh_we", 64'(awe), 64'd1);
    chk("sh_addr", aa, 64'h0);
    chk("sh_wstrb", 64'(aws), 64'hC0);
    chk("sh_wdata", awd, 64'hABCD000000000000);
    chk("sh_fault", 64'(fr), 64'd0);

    access(0, 1, 3'b010, 64'h8, 64'hDEADBEEF, 5, 99, 64'd0);
    chk("sw_wait_stall", 64'(ns), 64'd7);
    chk("sw_wait_req_cycles", 64'(nr), 64'd6);
    chk("sw_wait_unstable", 64'(nu), 64'd0);
    chk("sw_wait_wstrb", 64'(aws), 64'h0F);
    chk("sw_wait_wdata", awd, 64'h00000000DEADBEEF);

    access(1, 0, 3'b010, 64'h2, 64'd0, 0, 1, 64'h1111222287654321);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lw_mis_fault", 64'(fr), 64'd1);
    chk("lw_mis_req", 64'(nr), 64'd0);
    chk("lw_mis_data", rr, 64'd0);
`else
    chk("lw_mis_fault", 64'(fr), 64'd0);
    chk("lw_mis_req", 64'(nr), 64'd1);
    chk("lw_mis_data", rr, 64'hFFFFFFFF87654321);
`endif

    access(1, 0, 3'b001, 64'h6, 64'd0, 0, 1, 64'hBEEF000000000000);
    chk("lh_data", rr, 64'hFFFFFFFFFFFFBEEF);
    access(1, 0, 3'b110, 64'h4, 64'd0, 1, 3, 64'h9ABCDEF000000000);
    chk("lwu_data", rr, 64'h000000009ABCDEF0);
    chk("lwu_stall_cycles", 64'(ns), 64'd6);

    access(1, 0, 3'b111, 64'h0, 64'd0, 0, 1, 64'h5555);
    chk("ill_ld_fault", 64'(fr), 64'd1);
    chk("ill_ld_req", 64'(nr), 64'd0);
    chk("ill_ld_stall", 64'(ns), 64'd1);
    access(0, 1, 3'b100, 64'h0, 64'h77, 0, 99, 64'd0);
    chk("ill_st_fault", 64'(fr), 64'd1);
    chk("ill_st_req", 64'(nr), 64'd0);

    access(1, 1, 3'b000, 64'h1, 64'h5A, 0, 99, 64'd0);
    chk("rdwr_we", 64'(awe), 64'd1);
    chk("rdwr_wstrb", 64'(aws), 64'h02);
    chk("rdwr_wdata", awd, 64'h5A00);

    access(1, 0, 3'b011, 64'h0, 64'd0, 0, 999, 64'd0);
    chk("to_fault", 64'(fr), 64'd1);
    chk("to_data", rr, 64'd0);
    chk("to_stall_cycles", 64'(ns), 64'd10);

    access(1, 0, 3'b011, 64'h18, 64'd0, 0, 1, 64'hCAFEF00D12345678);
    chk("pre_rst_data", rr, 64'hCAFEF00D12345678);

    MemRead = 1'b1; funct3 = 3'b011; ALURes = 64'h20;
    @(posedge clk); #1;
    chk("rst_req_before", 64'(mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_req_async", 64'(mem_req), 64'd0);
    chk("rst_data_async", readData, 64'd0);
    MemRead = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("stray_rvalid_req", 64'(mem_req), 64'd0);
    chk("stray_rvalid_data", readData, 64'd0);
    mem_rvalid = 1'b0;
    access(1, 0, 3'b011, 64'h20, 64'd0, 0, 1, 64'h0123456789ABCDEF);
    chk("post_rst_stall", 64'(ns), 64'd3);
    chk("post_rst_data", rr, 64'h0123456789ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
